// File: rtl/seq_bypass_addsub_pkg.sv
// Shared types and defaults for the sequential block-bypass adder/subtractor.
package seq_bypass_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 32;
    localparam int K_DEF = 4;

endpackage

// File: rtl/seq_bypass_addsub_if.sv
// Operand/result handshake bundle for seq_bypass_addsub.
interface seq_bypass_addsub_if
    import seq_bypass_addsub_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
);
    localparam int CW = $clog2(N / K) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          of;
    logic [CW-1:0] bypass_cnt;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, of, bypass_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, of, bypass_cnt
    );

endinterface

// File: rtl/seq_bypass_addsub_bypass_block.sv
// One K-bit ripple slice with a propagate-AND carry bypass; purely combinational.
module bypass_block
    import seq_bypass_addsub_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic [K-1:0] a_blk,
    input  logic [K-1:0] b_blk,
    input  logic         cin_blk,
    output logic [K-1:0] sum_blk,
    output logic         cout_blk,
    output logic         bypassed
);

    always_comb begin : ripple
        logic c;
        c       = cin_blk;
        sum_blk = '0;
        for (int i = 0; i < K; i++) begin
            sum_blk[i] = a_blk[i] ^ b_blk[i] ^ c;
            c          = (a_blk[i] & b_blk[i]) | (c & (a_blk[i] ^ b_blk[i]));
        end
        // When every bit propagates the block carry-out equals its carry-in.
        bypassed = &(a_blk ^ b_blk);
        cout_blk = bypassed ? cin_blk : c;
    end

endmodule

// File: rtl/seq_bypass_addsub.sv
// Sequential N-bit add/sub processing K bits per cycle through a single reused
// bypass_block; counts how many block carries took the bypass path.
module seq_bypass_addsub
    import seq_bypass_addsub_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input logic                 clk,
    input logic                 rst,
    seq_bypass_addsub_if.slave  bus
);

    localparam int NB = N / K;
    localparam int IW = $clog2(NB) + 1;
    localparam int CW = $clog2(NB) + 1;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   a_q;
    logic [N-1:0]   beff_q;
    logic           carry_q;
    logic [IW-1:0]  idx;

    logic [N-1:0]   sum_q;
    logic           cout_q;
    logic           of_q;
    logic [CW-1:0]  cnt_q;

    logic [K-1:0]   a_blk;
    logic [K-1:0]   b_blk;
    logic [K-1:0]   sum_blk;
    logic           cout_blk;
    logic           bypassed;
    logic           last_blk;
    logic           settle;
    logic           c_msb;
    logic           in_ready;
    logic           out_valid;

    assign a_blk    = K'(a_q >> (K * idx));
    assign b_blk    = K'(beff_q >> (K * idx));
    assign last_blk = (idx == IW'(NB - 1));
    // One trailing RUN cycle after the MSB block puts out_valid N/K+1 cycles after accept.
    assign settle   = (idx == IW'(NB));
    assign c_msb    = a_q[N-1] ^ beff_q[N-1] ^ sum_blk[K-1];

    bypass_block #(.K(K)) u_blk (
        .a_blk    (a_blk),
        .b_blk    (b_blk),
        .cin_blk  (carry_q),
        .sum_blk  (sum_blk),
        .cout_blk (cout_blk),
        .bypassed (bypassed)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (settle)        state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_q    <= bus.a;
            beff_q <= bus.sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    carry_q <= bus.sub | bus.cin;
                    idx     <= '0;
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
                    of_q    <= 1'b0;
                    cnt_q   <= '0;
                end
                RUN: if (!settle) begin
                    for (int j = 0; j < NB; j++) begin
                        if (idx == IW'(j)) sum_q[j*K +: K] <= sum_blk;
                    end
                    carry_q <= cout_blk;
                    if (bypassed) cnt_q <= cnt_q + CW'(1);
                    if (last_blk) begin
                        cout_q <= cout_blk;
                        of_q   <= c_msb ^ cout_blk;
                    end
                    idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.sum        = sum_q;
    assign bus.cout       = cout_q;
    assign bus.of         = of_q;
    assign bus.bypass_cnt = cnt_q;

endmodule

// File: tb/tb_seq_bypass_addsub.sv
// Self-checking bench: directed corner vectors, random back-to-back traffic,
// DONE hold behaviour and resets in RUN/DONE against an arithmetic model.
module tb_seq_bypass_addsub;
    import seq_bypass_addsub_pkg::*;

    localparam int N  = 32;
    localparam int K  = 4;
    localparam int CW = $clog2(N / K) + 1;
    localparam int LAT = N / K + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_bypass_addsub_if #(.N(N), .K(K)) bus ();

    seq_bypass_addsub #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain wide-integer arithmetic plus per-block propagate count.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [N-1:0] s, output logic co,
                                  output logic ov, output logic [CW-1:0] bc);
        logic [N-1:0] be;
        logic         c;
        logic [N:0]   r;
        logic [N-1:0] x;
        int           n;
        be = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, c};
        s  = r[N-1:0];
        co = r[N];
        ov = (a[N-1] == be[N-1]) && (s[N-1] != a[N-1]);
        x  = a ^ be;
        n  = 0;
        for (int i = 0; i < N / K; i++) begin
            if (((x >> (i * K)) & {{(N-K){1'b0}}, {K{1'b1}}}) == {{(N-K){1'b0}}, {K{1'b1}}}) n++;
        end
        bc = CW'(n);
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub, input bit release_out,
                          output logic [N-1:0] s, output logic co, output logic ov,
                          output logic [CW-1:0] bc, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, lat);
        end
        s = bus.sum; co = bus.cout; ov = bus.of; bc = bus.bypass_cnt;
        if (release_out) begin
            @(negedge clk); bus.out_ready = 1'b1;
            @(posedge clk); #1; bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b, required 10", {bus.in_ready, bus.out_valid});
        end
        total++;
        if ({bus.sum, bus.cout, bus.of, bus.bypass_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: sum=%h cout=%b of=%b cnt=%0d, required all 0",
                     bus.sum, bus.cout, bus.of, bus.bypass_cnt);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] va [7] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA,
                                 32'h00000005, 32'h80000000, 32'h12345678};
        logic [N-1:0] vb [7] = '{32'h00000001, 32'h00000001, 32'h55555555, 32'h55555555,
                                 32'h00000007, 32'h00000001, 32'h00000000};
        logic         vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] s, es;
        logic co, ov, eco, eov;
        logic [CW-1:0] bc, ebc;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], 1'b1, s, co, ov, bc, lat);
            model(va[i], vb[i], vc[i], vs[i], es, eco, eov, ebc);
            total++;
            if ({s, co, ov, bc} !== {es, eco, eov, ebc}) begin
                bad++;
                $display("FAIL directed_%0d: sum=%h cout=%b of=%b cnt=%0d, required sum=%h cout=%b of=%b cnt=%0d",
                         i, s, co, ov, bc, es, eco, eov, ebc);
            end
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL directed_latency_%0d: %0d cycles, required %0d", i, lat, LAT);
            end
            total++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL directed_release_%0d: in_ready=%b out_valid=%b, required 1/0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
        // Subtracting zero must return a unchanged with carry out set.
        total++;
        if ({s, co} !== {va[6], 1'b1}) begin
            bad++;
            $display("FAIL sub_zero: sum=%h cout=%b, required sum=%h cout=1", s, co, va[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b, s, es;
        logic cin, sub, co, ov, eco, eov;
        logic [CW-1:0] bc, ebc;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? ~a : N'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            if (sub && $urandom_range(0, 3) == 0) b = a;
            run_op(a, b, cin, sub, 1'b1, s, co, ov, bc, lat);
            model(a, b, cin, sub, es, eco, eov, ebc);
            total++;
            if ({s, co, ov, bc} !== {es, eco, eov, ebc} || lat !== LAT) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b of=%b cnt=%0d lat=%0d, required sum=%h cout=%b of=%b cnt=%0d lat=%0d",
                         i, a, b, cin, sub, s, co, ov, bc, lat, es, eco, eov, ebc, LAT);
            end
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] a0, b0, s0, es;
        logic co0, ov0, eco, eov;
        logic [CW-1:0] bc0, ebc;
        int lat;
        a0 = $urandom; b0 = $urandom;
        model(a0, b0, 1'b1, 1'b0, es, eco, eov, ebc);
        @(negedge clk);
        bus.a = a0; bus.b = b0; bus.cin = 1'b1; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.in_valid = (c == 3);
            if (c == 3) begin bus.a = ~a0; bus.b = 32'h0000FFFF; bus.sub = 1'b1; end
            @(posedge clk); #1;
            lat = c;
            if (bus.out_valid === 1'b1) break;
        end
        bus.in_valid = 1'b0;
        s0 = bus.sum; co0 = bus.cout; ov0 = bus.of; bc0 = bus.bypass_cnt;
        total++;
        if ({s0, co0, ov0, bc0} !== {es, eco, eov, ebc} || lat !== LAT) begin
            bad++;
            $display("FAIL hold_result: sum=%h cout=%b of=%b cnt=%0d lat=%0d, required sum=%h cout=%b of=%b cnt=%0d lat=%0d",
                     s0, co0, ov0, bc0, lat, es, eco, eov, ebc, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 2);
            bus.a = $urandom;
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.sum, bus.cout, bus.of, bus.bypass_cnt} !== {s0, co0, ov0, bc0}) begin
                bad++;
                $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b sum=%h cout=%b of=%b cnt=%0d, required 1/0 sum=%h cout=%b of=%b cnt=%0d",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.of, bus.bypass_cnt, s0, co0, ov0, bc0);
            end
        end
        @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_no_second_accept: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] a, b, s, es;
        logic co, ov, eco, eov;
        logic [CW-1:0] bc, ebc;
        int lat;
        @(negedge clk);
        bus.a = 32'h0000_1357; bus.b = 32'h0000_2468; bus.cin = 1'b1; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 ||
            {bus.sum, bus.cout, bus.of, bus.bypass_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_run: in_ready=%b out_valid=%b sum=%h cout=%b of=%b cnt=%0d, required 1/0 and zeros",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.of, bus.bypass_cnt);
        end
        @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        a = $urandom; b = $urandom;
        run_op(a, b, 1'b0, 1'b1, 1'b0, s, co, ov, bc, lat);
        model(a, b, 1'b0, 1'b1, es, eco, eov, ebc);
        total++;
        if ({s, co, ov, bc} !== {es, eco, eov, ebc} || lat !== LAT) begin
            bad++;
            $display("FAIL after_reset_op: sum=%h cout=%b of=%b cnt=%0d lat=%0d, required sum=%h cout=%b of=%b cnt=%0d lat=%0d",
                     s, co, ov, bc, lat, es, eco, eov, ebc, LAT);
        end
        // Left in DONE on purpose: reset must also abandon a held result.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 ||
            {bus.sum, bus.cout, bus.of, bus.bypass_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_done: in_ready=%b out_valid=%b sum=%h cout=%b of=%b cnt=%0d, required 1/0 and zeros",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.of, bus.bypass_cnt);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
